// File: rtl/axi4_lite_pkg.sv
// Shared types and helpers for the AXI4-Lite memory slave.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    // Number of address bits that select a byte within one data word.
    function automatic int byte_off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/axi4_lite_mem_array.sv
// DEPTH x DATA_W storage: byte-enable write port, registered read port (read-before-write).
module axi4_lite_mem_array
    import axi4_lite_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [STRB_W-1:0] i_wstrb,
    input  logic              i_re,
    input  logic [IDX_W-1:0]  i_raddr,
    input  logic              i_rzero,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Contents deliberately have no reset so data survives ARESETn.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (i_wstrb[i]) begin
                    r_mem[i_waddr][i*8 +: 8] <= i_wdata[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= i_rzero ? '0 : r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axi4_lite_mem_slave.sv
// Parametrised AXI4-Lite scratchpad slave with independent AW/W holding registers.
// Define AXI4_LITE_MEM_OOR_ERR_EN to return SLVERR for out-of-range accesses instead of wrapping.
module axi4_lite_mem_slave
    import axi4_lite_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    input  logic [ADDR_W-1:0]   ARADDR,
    input  logic                ARVALID,
    output logic                ARREADY,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP,
    output logic                RVALID,
    input  logic                RREADY
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = byte_off_w(DATA_W);
    localparam int IDX_W  = $clog2(DEPTH);
`ifdef AXI4_LITE_MEM_OOR_ERR_EN
    localparam bit OOR_ERR = 1'b1;
`else
    localparam bit OOR_ERR = 1'b0;
`endif

    logic              r_aw_full;
    logic [ADDR_W-1:0] r_awaddr;
    logic              r_w_full;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic              r_bvalid;
    resp_t             r_bresp;
    logic              r_rvalid;
    resp_t             r_rresp;

    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_ar_hs;
    logic              w_commit;
    logic [ADDR_W-1:0] w_aw_word;
    logic [ADDR_W-1:0] w_ar_word;
    logic              w_aw_inrange;
    logic              w_ar_inrange;
    logic              w_we;
    logic              w_rzero;

    assign w_aw_hs  = AWVALID && !r_aw_full;
    assign w_w_hs   = WVALID && !r_w_full;
    assign w_ar_hs  = ARVALID && !r_rvalid;
    assign w_commit = r_aw_full && r_w_full && !r_bvalid;

    // Word index keeps all upper bits so the range check sees addresses beyond DEPTH.
    assign w_aw_word    = r_awaddr >> OFF_W;
    assign w_ar_word    = ARADDR >> OFF_W;
    assign w_aw_inrange = w_aw_word < ADDR_W'(DEPTH);
    assign w_ar_inrange = w_ar_word < ADDR_W'(DEPTH);
    assign w_we         = w_commit && (w_aw_inrange || !OOR_ERR);
    assign w_rzero      = OOR_ERR && !w_ar_inrange;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
        end else begin
            if (w_commit) begin
                r_aw_full <= 1'b0;
            end else if (w_aw_hs) begin
                r_aw_full <= 1'b1;
            end
            if (w_commit) begin
                r_w_full <= 1'b0;
            end else if (w_w_hs) begin
                r_w_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_aw_hs) begin
            r_awaddr <= AWADDR;
        end
        if (w_w_hs) begin
            r_wdata <= WDATA;
            r_wstrb <= WSTRB;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_bvalid <= 1'b0;
            r_bresp  <= OKAY;
        end else if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= (OOR_ERR && !w_aw_inrange) ? SLVERR : OKAY;
        end else if (BREADY) begin
            r_bvalid <= 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_rvalid <= 1'b0;
            r_rresp  <= OKAY;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rresp  <= w_rzero ? SLVERR : OKAY;
        end else if (RREADY) begin
            r_rvalid <= 1'b0;
        end
    end

    axi4_lite_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .i_clk   (ACLK),
        .i_rst_n (ARESETn),
        .i_we    (w_we),
        .i_waddr (w_aw_word[IDX_W-1:0]),
        .i_wdata (r_wdata),
        .i_wstrb (r_wstrb),
        .i_re    (w_ar_hs),
        .i_raddr (w_ar_word[IDX_W-1:0]),
        .i_rzero (w_rzero),
        .o_rdata (RDATA)
    );

    assign AWREADY = !r_aw_full;
    assign WREADY  = !r_w_full;
    assign ARREADY = !r_rvalid;
    assign BVALID  = r_bvalid;
    assign BRESP   = r_bresp;
    assign RVALID  = r_rvalid;
    assign RRESP   = r_rresp;

endmodule

// File: tb/tb_axi4_lite_mem_slave.sv
// Self-checking bench for axi4_lite_mem_slave (default 32-bit, 256-word build); honours AXI4_LITE_MEM_OOR_ERR_EN.
`define CHK(nm, g, e) chk(nm, 64'(g), 64'(e))

module tb_axi4_lite_mem_slave;

`ifdef AXI4_LITE_MEM_OOR_ERR_EN
    localparam bit OOR = 1'b1;
`else
    localparam bit OOR = 1'b0;
`endif

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [31:0] AWADDR = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b1;
    logic [31:0] ARADDR = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY = 1'b1;

    axi4_lite_mem_slave dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 ACLK = ~ACLK;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endfunction

    function automatic void fail(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_fail++;
        $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    endfunction

    // Transaction-level reference: pending requests as queues, memory as a word array.
    logic [31:0] m_mem [256];
    logic [31:0] q_aw [$];
    logic [35:0] q_w [$];
    bit          m_bv = 1'b0;
    logic [1:0]  m_bresp = 2'b00;
    bit          m_rv = 1'b0;
    logic [1:0]  m_rresp = 2'b00;
    logic [31:0] m_rdata = '0;

    task automatic model_step();
        bit aw_acc, w_acc, ar_acc, commit, b_clr, r_clr;
        logic [31:0] a, word;
        logic [35:0] w;
        if (!ARESETn) begin
            q_aw.delete();
            q_w.delete();
            m_bv = 1'b0; m_bresp = 2'b00;
            m_rv = 1'b0; m_rresp = 2'b00; m_rdata = '0;
            return;
        end
        aw_acc = AWVALID && (q_aw.size() == 0);
        w_acc  = WVALID && (q_w.size() == 0);
        ar_acc = ARVALID && !m_rv;
        commit = (q_aw.size() != 0) && (q_w.size() != 0) && !m_bv;
        b_clr  = m_bv && BREADY;
        r_clr  = m_rv && RREADY;
        if (ar_acc) begin
            word = ARADDR >> 2;
            if (OOR && word >= 32'd256) begin
                m_rdata = '0; m_rresp = 2'b10;
            end else begin
                m_rdata = m_mem[word[7:0]]; m_rresp = 2'b00;
            end
            m_rv = 1'b1;
        end else if (r_clr) begin
            m_rv = 1'b0;
        end
        if (b_clr) m_bv = 1'b0;
        if (commit) begin
            a = q_aw.pop_front();
            w = q_w.pop_front();
            word = a >> 2;
            if (OOR && word >= 32'd256) begin
                m_bresp = 2'b10;
            end else begin
                for (int i = 0; i < 4; i++)
                    if (w[32+i]) m_mem[word[7:0]][8*i +: 8] = w[8*i +: 8];
                m_bresp = 2'b00;
            end
            m_bv = 1'b1;
        end
        if (aw_acc) q_aw.push_back(AWADDR);
        if (w_acc) q_w.push_back({WSTRB, WDATA});
    endtask

    initial forever begin
        @(posedge ACLK or negedge ARESETn);
        model_step();
    end

    always @(negedge ACLK) begin
        if (chk_en) begin
            n_chk += 6;
            if (AWREADY !== (q_aw.size() == 0)) fail("awready", AWREADY, q_aw.size() == 0);
            if (WREADY !== (q_w.size() == 0)) fail("wready", WREADY, q_w.size() == 0);
            if (ARREADY !== !m_rv) fail("arready", ARREADY, !m_rv);
            if (BVALID !== m_bv) fail("bvalid", BVALID, m_bv);
            if (m_bv) begin
                n_chk++;
                if (BRESP !== m_bresp) fail("bresp", BRESP, m_bresp);
            end
            if (RVALID !== m_rv) fail("rvalid", RVALID, m_rv);
            if (m_rv) begin
                n_chk++;
                if (RRESP !== m_rresp) fail("rresp", RRESP, m_rresp);
            end
            if (RDATA !== m_rdata) fail("rdata", RDATA, m_rdata);
        end
    end

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input bit wait_b, output logic [1:0] r);
        int n = 0;
        bit aw_go, w_go;
        r = 2'b00;
        AWADDR = a; AWVALID = 1'b1; WDATA = d; WSTRB = s; WVALID = 1'b1;
        while ((AWVALID || WVALID) && n < 50) begin
            aw_go = AWVALID && AWREADY;
            w_go  = WVALID && WREADY;
            @(negedge ACLK);
            n++;
            if (aw_go) AWVALID = 1'b0;
            if (w_go) WVALID = 1'b0;
        end
        `CHK("aw_w_accept_timeout", AWVALID || WVALID, 0);
        AWVALID = 1'b0; WVALID = 1'b0;
        if (wait_b) begin
            n = 0;
            while (!BVALID && n < 50) begin
                @(negedge ACLK);
                n++;
            end
            `CHK("b_timeout", BVALID, 1);
            r = BRESP;
            if (BREADY) @(negedge ACLK);
        end
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        int n = 0;
        ARADDR = a; ARVALID = 1'b1;
        while (!ARREADY && n < 50) begin
            @(negedge ACLK);
            n++;
        end
        `CHK("ar_timeout", n < 50, 1);
        @(negedge ACLK);
        ARVALID = 1'b0;
        `CHK("r_latency", RVALID, 1);
        d = RDATA;
        r = RRESP;
        if (RREADY) @(negedge ACLK);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] w;
        case ($urandom_range(0, 5))
            0:       w = $urandom_range(256, 300);
            1, 2:    w = $urandom_range(0, 3);
            default: w = $urandom_range(0, 255);
        endcase
        return (w << 2) | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  r;
        logic [31:0] d;
        bit aw_prev, w_prev, ar_prev;

        repeat (2) @(negedge ACLK);
        n_chk += 3;
        if (AWREADY !== 1'b1) fail("rst_awready", AWREADY, 1);
        if (WREADY !== 1'b1) fail("rst_wready", WREADY, 1);
        if (ARREADY !== 1'b1) fail("rst_arready", ARREADY, 1);
        `CHK("rst_bvalid", BVALID, 0);
        `CHK("rst_rvalid", RVALID, 0);
        `CHK("rst_bresp", BRESP, 0);
        `CHK("rst_rresp", RRESP, 0);
        `CHK("rst_rdata", RDATA, 0);
        ARESETn = 1'b1;
        chk_en = 1'b1;
        @(negedge ACLK);

        for (int i = 0; i < 256; i++) begin
            do_write(32'(i) << 2, $urandom, 4'hF, 1'b1, r);
            `CHK("preload_bresp", r, 0);
        end

        do_write(32'h10, 32'hDEADBEEF, 4'hF, 1'b1, r);
        `CHK("t1_bresp", r, 0);
        do_read(32'h10, d, r);
        n_chk++;
        if (d !== 32'hDEADBEEF) fail("t1_rdata", d, 32'hDEADBEEF);
        `CHK("t1_rresp", r, 0);

        do_write(32'h10, 32'h000000AA, 4'h1, 1'b1, r);
        do_read(32'h10, d, r);
        n_chk++;
        if (d !== 32'hDEADBEAA) fail("t2_rdata", d, 32'hDEADBEAA);

        `CHK("t3_wready_pre", WREADY, 1);
        WDATA = 32'h12345678; WSTRB = 4'hF; WVALID = 1'b1;
        @(negedge ACLK);
        WVALID = 1'b0;
        `CHK("t3_wready_drop", WREADY, 0);
        repeat (2) @(negedge ACLK);
        `CHK("t3_wready_held", WREADY, 0);
        `CHK("t3_no_b_yet", BVALID, 0);
        AWADDR = 32'h20; AWVALID = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0;
        `CHK("t3_b_not_before_commit", BVALID, 0);
        @(negedge ACLK);
        `CHK("t3_bvalid", BVALID, 1);
        `CHK("t3_bresp", BRESP, 0);
        `CHK("t3_wready_back", WREADY, 1);
        @(negedge ACLK);
        `CHK("t3_b_done", BVALID, 0);
        do_read(32'h20, d, r);
        `CHK("t3_rdata", d, 32'h12345678);

        BREADY = 1'b0;
        do_write(32'h30, 32'h11111111, 4'hF, 1'b0, r);
        @(negedge ACLK);
        `CHK("t4_bvalid", BVALID, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            `CHK("t4_bvalid_hold", BVALID, 1);
            `CHK("t4_bresp_hold", BRESP, 0);
            `CHK("t4_awready", AWREADY, 1);
            `CHK("t4_wready", WREADY, 1);
        end
        do_write(32'h34, 32'h22222222, 4'hF, 1'b0, r);
        for (int i = 0; i < 3; i++) begin
            `CHK("t4_awready_blocked", AWREADY, 0);
            `CHK("t4_wready_blocked", WREADY, 0);
            `CHK("t4_first_b_hold", BVALID, 1);
            @(negedge ACLK);
        end
        BREADY = 1'b1;
        @(negedge ACLK);
        `CHK("t4_b1_cleared", BVALID, 0);
        `CHK("t4_still_pending", AWREADY, 0);
        @(negedge ACLK);
        `CHK("t4_b2_valid", BVALID, 1);
        `CHK("t4_awready_free", AWREADY, 1);
        @(negedge ACLK);
        do_read(32'h34, d, r);
        `CHK("t4_rdata2", d, 32'h22222222);
        do_read(32'h30, d, r);
        `CHK("t4_rdata1", d, 32'h11111111);

        RREADY = 1'b0;
        ARADDR = 32'h10; ARVALID = 1'b1;
        @(negedge ACLK);
        ARVALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            `CHK("t5_rvalid_hold", RVALID, 1);
            `CHK("t5_rdata_hold", RDATA, 32'hDEADBEAA);
            `CHK("t5_arready_low", ARREADY, 0);
            @(negedge ACLK);
        end
        RREADY = 1'b1;
        @(negedge ACLK);
        `CHK("t5_rvalid_clr", RVALID, 0);
        `CHK("t5_arready_back", ARREADY, 1);
        `CHK("t5_rdata_kept", RDATA, 32'hDEADBEAA);

        do_write(32'h0, 32'hCAFEF00D, 4'hF, 1'b1, r);
        do_write(32'h400, 32'h55555555, 4'hF, 1'b1, r);
        `CHK("t6_oor_bresp", r, OOR ? 2'b10 : 2'b00);
        do_read(32'h0, d, r);
        `CHK("t6_word0", d, OOR ? 32'hCAFEF00D : 32'h55555555);
        do_read(32'h400, d, r);
        `CHK("t6_oor_rdata", d, OOR ? 32'h0 : 32'h55555555);
        `CHK("t6_oor_rresp", r, OOR ? 2'b10 : 2'b00);

        aw_prev = 1'b0; w_prev = 1'b0; ar_prev = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (!AWVALID || aw_prev) begin
                AWVALID = ($urandom_range(0, 2) != 0);
                AWADDR = rand_addr();
            end
            if (!WVALID || w_prev) begin
                WVALID = ($urandom_range(0, 2) != 0);
                WDATA = $urandom;
                WSTRB = 4'($urandom_range(0, 15));
            end
            if (!ARVALID || ar_prev) begin
                ARVALID = ($urandom_range(0, 2) != 0);
                ARADDR = rand_addr();
            end
            BREADY = ($urandom_range(0, 3) != 0);
            RREADY = ($urandom_range(0, 3) != 0);
            aw_prev = AWVALID && AWREADY;
            w_prev  = WVALID && WREADY;
            ar_prev = ARVALID && ARREADY;
            @(negedge ACLK);
        end
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        BREADY = 1'b1; RREADY = 1'b1;
        repeat (10) @(negedge ACLK);

        do_write(32'h40, 32'hA5A55A5A, 4'hF, 1'b1, r);
        BREADY = 1'b0;
        do_write(32'h44, 32'h0F0F0F0F, 4'hF, 1'b0, r);
        @(negedge ACLK);
        `CHK("t7_bvalid_before_rst", BVALID, 1);
        AWADDR = 32'h48; AWVALID = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0;
        `CHK("t7_aw_held", AWREADY, 0);
        #2 ARESETn = 1'b0;
        @(negedge ACLK);
        `CHK("t7_rst_bvalid", BVALID, 0);
        `CHK("t7_rst_awready", AWREADY, 1);
        ARESETn = 1'b1;
        BREADY = 1'b1;
        @(negedge ACLK);
        `CHK("t7_post_bvalid", BVALID, 0);
        `CHK("t7_post_awready", AWREADY, 1);
        `CHK("t7_post_wready", WREADY, 1);
        `CHK("t7_post_rdata", RDATA, 0);
        do_read(32'h40, d, r);
        `CHK("t7_mem_kept0", d, 32'hA5A55A5A);
        do_read(32'h44, d, r);
        `CHK("t7_mem_kept1", d, 32'h0F0F0F0F);

        repeat (2) @(negedge ACLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
